// File: rtl/mem_stage_sb.sv
// MEM-stage load/store unit: RV32 sub-word formatting plus an in-order store buffer that
// drains in the background and forwards buffered bytes to younger loads.
module mem_stage_sb #(
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned SB_DEPTH = 4,
   parameter bit          FWD_EN   = 1'b1
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              MEM_READ_EN,
   input  logic              MEM_WRITE_EN,
   input  logic [2:0]        FUNC3,
   input  logic [ADDR_W-1:0] ADDR,
   input  logic [31:0]       WRITE_DATA,
   output logic [31:0]       READ_DATA,
   output logic              MEM_BUSYWAIT,
   output logic              MISALIGN,
   output logic              SB_FULL,
   output logic              SB_EMPTY,
   output logic              DM_REQ,
   output logic              DM_WE,
   output logic [ADDR_W-1:0] DM_ADDR,
   output logic [31:0]       DM_WDATA,
   output logic [3:0]        DM_BE,
   input  logic [31:0]       DM_RDATA,
   input  logic              DM_ACK
);

   localparam int unsigned PW = $clog2(SB_DEPTH);

   typedef enum logic [1:0] {StIdle, StDrain, StLoad, StLdone} state_e;

   logic [ADDR_W-1:0] sb_addr_q [SB_DEPTH];
   logic [3:0]        sb_be_q   [SB_DEPTH];
   logic [31:0]       sb_data_q [SB_DEPTH];
   logic [SB_DEPTH-1:0] sb_valid_q;
   logic [PW-1:0]     head_q, tail_q;
   logic [PW:0]       count_q;

   state_e            state_q;
   logic              dm_req_q, dm_we_q;
   logic [ADDR_W-1:0] dm_addr_q;
   logic [31:0]       dm_wdata_q, ld_data_q;
   logic [3:0]        dm_be_q;

   logic              misalign, st_req, ld_req, full, enq, deq;
   logic              any_match, fwd_ok;
   logic [ADDR_W-1:0] word_addr;
   logic [3:0]        acc_be, mrg_be;
   logic [31:0]       st_data, mrg_data;
   logic [PW-1:0]     idx;

   function automatic logic [31:0] fmt_load(logic [31:0] w, logic [2:0] f3, logic [1:0] off);
      logic [31:0] s;
      logic [31:0] r;
      s = w >> {off, 3'b000};
      case (f3)
         3'b000:  r = {{24{s[7]}}, s[7:0]};
         3'b001:  r = {{16{s[15]}}, s[15:0]};
         3'b100:  r = {24'h0, s[7:0]};
         3'b101:  r = {16'h0, s[15:0]};
         default: r = s;
      endcase
      return r;
   endfunction

   always_comb begin
      misalign  = (FUNC3[1:0] == 2'b01 && ADDR[0]) || (FUNC3[1] && ADDR[1:0] != 2'b00);
      word_addr = {ADDR[ADDR_W-1:2], 2'b00};
      if (FUNC3[1])              acc_be = 4'b1111;
      else if (FUNC3[0])         acc_be = ADDR[1] ? 4'b1100 : 4'b0011;
      else                       acc_be = 4'b0001 << ADDR[1:0];
      st_data = WRITE_DATA << {ADDR[1:0], 3'b000};
      // A simultaneous read+write is a store only.
      st_req  = MEM_WRITE_EN && !misalign;
      ld_req  = MEM_READ_EN && !MEM_WRITE_EN && !misalign;
      full    = (count_q == (PW+1)'(SB_DEPTH));
      enq     = st_req && !full;
      deq     = (state_q == StDrain) && DM_ACK;
   end

   // Walk entries oldest to youngest so the youngest writer of each byte wins.
   always_comb begin
      mrg_be    = 4'b0000;
      mrg_data  = 32'h0;
      any_match = 1'b0;
      idx       = head_q;
      for (int i = 0; i < int'(SB_DEPTH); i++) begin
         idx = head_q + PW'(i);
         if (sb_valid_q[idx] && sb_addr_q[idx] == word_addr) begin
            any_match = 1'b1;
            for (int b = 0; b < 4; b++) begin
               if (sb_be_q[idx][b]) begin
                  mrg_be[b]         = 1'b1;
                  mrg_data[8*b +: 8] = sb_data_q[idx][8*b +: 8];
               end
            end
         end
      end
      fwd_ok = FWD_EN && any_match && ((mrg_be & acc_be) == acc_be);
   end

   always_comb begin
      MISALIGN     = (MEM_READ_EN || MEM_WRITE_EN) && misalign;
      MEM_BUSYWAIT = (state_q != StLdone) && ((st_req && full) || (ld_req && !fwd_ok));
      if (state_q == StLdone)     READ_DATA = ld_data_q;
      else if (ld_req && fwd_ok)  READ_DATA = fmt_load(mrg_data, FUNC3, ADDR[1:0]);
      else                        READ_DATA = 32'h0;
      SB_FULL  = full;
      SB_EMPTY = (count_q == '0);
      DM_REQ   = dm_req_q;
      DM_WE    = dm_we_q;
      DM_ADDR  = dm_addr_q;
      DM_WDATA = dm_wdata_q;
      DM_BE    = dm_be_q;
   end

   always_ff @(posedge CLK) begin
      if (enq) begin
         sb_addr_q[tail_q] <= word_addr;
         sb_be_q[tail_q]   <= acc_be;
         sb_data_q[tail_q] <= st_data;
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         sb_valid_q <= '0;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
      end else begin
         if (enq) begin
            sb_valid_q[tail_q] <= 1'b1;
            tail_q             <= tail_q + 1'b1;
         end
         if (deq) begin
            sb_valid_q[head_q] <= 1'b0;
            head_q             <= head_q + 1'b1;
         end
         count_q <= count_q + (PW+1)'(enq) - (PW+1)'(deq);
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q    <= StIdle;
         dm_req_q   <= 1'b0;
         dm_we_q    <= 1'b0;
         dm_addr_q  <= '0;
         dm_wdata_q <= 32'h0;
         dm_be_q    <= 4'b0000;
         ld_data_q  <= 32'h0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (ld_req && !any_match) begin
                  state_q    <= StLoad;
                  dm_req_q   <= 1'b1;
                  dm_we_q    <= 1'b0;
                  dm_addr_q  <= word_addr;
                  dm_wdata_q <= 32'h0;
                  dm_be_q    <= 4'b1111;
               end else if (count_q != '0) begin
                  state_q    <= StDrain;
                  dm_req_q   <= 1'b1;
                  dm_we_q    <= 1'b1;
                  dm_addr_q  <= sb_addr_q[head_q];
                  dm_wdata_q <= sb_data_q[head_q];
                  dm_be_q    <= sb_be_q[head_q];
               end
            end
            StDrain, StLoad: begin
               if (DM_ACK) begin
                  if (state_q == StLoad) begin
                     ld_data_q <= fmt_load(DM_RDATA, FUNC3, ADDR[1:0]);
                     state_q   <= StLdone;
                  end else begin
                     state_q   <= StIdle;
                  end
                  dm_req_q   <= 1'b0;
                  dm_we_q    <= 1'b0;
                  dm_addr_q  <= '0;
                  dm_wdata_q <= 32'h0;
                  dm_be_q    <= 4'b0000;
               end
            end
            StLdone: state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage_sb.sv
// Randomised bench for mem_stage_sb: architectural byte-memory model, pending-store queue
// and a DM responder with random ACK latency.
module tb_mem_stage_sb;

   localparam int unsigned DEPTH = 4;
   localparam bit          FWD   = 1'b1;

   logic        CLK, RESET, MEM_READ_EN, MEM_WRITE_EN;
   logic [2:0]  FUNC3;
   logic [31:0] ADDR, WRITE_DATA, READ_DATA, DM_ADDR, DM_WDATA, DM_RDATA;
   logic        MEM_BUSYWAIT, MISALIGN, SB_FULL, SB_EMPTY, DM_REQ, DM_WE, DM_ACK;
   logic [3:0]  DM_BE;

   mem_stage_sb #(.ADDR_W(32), .SB_DEPTH(DEPTH), .FWD_EN(FWD)) dut (
      .CLK(CLK), .RESET(RESET), .MEM_READ_EN(MEM_READ_EN), .MEM_WRITE_EN(MEM_WRITE_EN),
      .FUNC3(FUNC3), .ADDR(ADDR), .WRITE_DATA(WRITE_DATA), .READ_DATA(READ_DATA),
      .MEM_BUSYWAIT(MEM_BUSYWAIT), .MISALIGN(MISALIGN), .SB_FULL(SB_FULL), .SB_EMPTY(SB_EMPTY),
      .DM_REQ(DM_REQ), .DM_WE(DM_WE), .DM_ADDR(DM_ADDR), .DM_WDATA(DM_WDATA), .DM_BE(DM_BE),
      .DM_RDATA(DM_RDATA), .DM_ACK(DM_ACK)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] data;
   } st_t;

   st_t          pend[$];
   logic [7:0]   golden  [int unsigned];
   logic [7:0]   backing [int unsigned];
   int           n_tests, n_fail;
   bit           resp_en;
   int           fixed_delay;
   logic [31:0]  cur_ld_addr;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic [7:0] init_byte(int unsigned a);
      return 8'(a * 37 + 11);
   endfunction

   function automatic logic [7:0] gbyte(int unsigned a);
      if (golden.exists(a)) return golden[a];
      return init_byte(a);
   endfunction

   function automatic logic [7:0] bbyte(int unsigned a);
      if (backing.exists(a)) return backing[a];
      return init_byte(a);
   endfunction

   function automatic int nbytes(logic [2:0] f3);
      return f3[1] ? 4 : (f3[0] ? 2 : 1);
   endfunction

   function automatic bit exp_mis(logic [31:0] a, logic [2:0] f3);
      int n = nbytes(f3);
      return (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
   endfunction

   // Architectural value: read the bytes at a..a+n-1 and extend.
   function automatic logic [31:0] exp_load(logic [31:0] a, logic [2:0] f3);
      int n = nbytes(f3);
      logic [31:0] v = 32'h0;
      for (int b = 0; b < n; b++) v[8*b +: 8] = gbyte(a + b);
      if (!f3[2] && n == 1 && v[7])  v[31:8]  = '1;
      if (!f3[2] && n == 2 && v[15]) v[31:16] = '1;
      return v;
   endfunction

   function automatic bit covered(logic [31:0] a, logic [2:0] f3);
      int n = nbytes(f3);
      logic [3:0] need = 4'b0000;
      logic [3:0] uni  = 4'b0000;
      bit any = 1'b0;
      for (int b = 0; b < n; b++) begin
         int k = int'(a[1:0]) + b;
         if (k < 4) need[k] = 1'b1;
      end
      foreach (pend[i]) begin
         if (pend[i].addr == {a[31:2], 2'b00}) begin
            any = 1'b1;
            uni = uni | pend[i].be;
         end
      end
      return any && ((uni & need) == need);
   endfunction

   task automatic idle(input int n);
      @(negedge CLK);
      MEM_READ_EN = 1'b0; MEM_WRITE_EN = 1'b0;
      repeat (n) @(posedge CLK);
   endtask

   task automatic do_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d,
                           input bit both);
      st_t e;
      int  n;
      @(negedge CLK);
      MEM_WRITE_EN = 1'b1; MEM_READ_EN = both; FUNC3 = f3; ADDR = a; WRITE_DATA = d;
      #1;
      check_eq("st_misalign", MISALIGN, exp_mis(a, f3));
      if (exp_mis(a, f3)) begin
         check_eq("st_mis_busy", MEM_BUSYWAIT, 0);
         check_eq("st_mis_rdata", READ_DATA, 0);
         return;
      end
      check_eq("st_sb_full", SB_FULL, pend.size() == DEPTH);
      check_eq("st_sb_empty", SB_EMPTY, pend.size() == 0);
      for (int cyc = 0; ; cyc++) begin
         check_eq("st_busy", MEM_BUSYWAIT, pend.size() == DEPTH);
         if (!MEM_BUSYWAIT) break;
         if (cyc == 200) begin
            check_eq("st_timeout", MEM_BUSYWAIT, 0);
            return;
         end
         @(negedge CLK); #1;
      end
      n      = nbytes(f3);
      e.addr = {a[31:2], 2'b00};
      e.be   = 4'b0000;
      e.data = 32'h0;
      for (int b = 0; b < n; b++) begin
         golden[a + b] = d[8*b +: 8];
         e.be[int'(a[1:0]) + b]            = 1'b1;
         e.data[8*(int'(a[1:0]) + b) +: 8] = d[8*b +: 8];
      end
      pend.push_back(e);
   endtask

   task automatic do_load(input logic [31:0] a, input logic [2:0] f3, output int busy);
      logic [31:0] exp;
      busy = 0;
      @(negedge CLK);
      MEM_WRITE_EN = 1'b0; MEM_READ_EN = 1'b1; FUNC3 = f3; ADDR = a; cur_ld_addr = a;
      #1;
      check_eq("ld_misalign", MISALIGN, exp_mis(a, f3));
      if (exp_mis(a, f3)) begin
         check_eq("ld_mis_busy", MEM_BUSYWAIT, 0);
         check_eq("ld_mis_rdata", READ_DATA, 0);
         return;
      end
      exp = exp_load(a, f3);
      check_eq("ld_stall", MEM_BUSYWAIT, !(FWD && covered(a, f3)));
      while (MEM_BUSYWAIT && busy < 200) begin
         busy++;
         @(negedge CLK); #1;
      end
      if (MEM_BUSYWAIT) check_eq("ld_timeout", MEM_BUSYWAIT, 0);
      else              check_eq("ld_data", READ_DATA, exp);
   endtask

   task automatic wait_empty();
      idle(1);
      for (int i = 0; i < 200 && !SB_EMPTY; i++) @(negedge CLK);
      #1;
      check_eq("wait_empty", SB_EMPTY, 1);
   endtask

   task automatic disable_resp();
      @(negedge CLK);
      while (DM_ACK) @(negedge CLK);
      resp_en = 1'b0;
   endtask

   // Memory responder: decides ACK just after each rising edge.
   initial begin
      bit          in_req, last_we;
      int          wait_cnt;
      logic [31:0] last_addr, last_wdata;
      logic [3:0]  last_be;
      in_req = 1'b0; wait_cnt = 0; last_we = 1'b0;
      last_addr = 32'h0; last_wdata = 32'h0; last_be = 4'b0000;
      DM_ACK = 1'b0; DM_RDATA = 32'h0;
      forever begin
         @(posedge CLK); #1;
         if (!resp_en) begin
            in_req = 1'b0;
         end else if (DM_ACK) begin
            DM_ACK = 1'b0;
            in_req = 1'b0;
            if (last_we) begin
               for (int b = 0; b < 4; b++)
                  if (last_be[b]) backing[last_addr + b] = last_wdata[8*b +: 8];
               if (pend.size() > 0) void'(pend.pop_front());
            end
         end else if (DM_REQ) begin
            if (!in_req) begin
               in_req   = 1'b1;
               wait_cnt = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
            end
            if (wait_cnt == 0) begin
               if (DM_WE) begin
                  if (pend.size() > 0) begin
                     check_eq("dm_waddr", DM_ADDR, pend[0].addr);
                     check_eq("dm_wbe", DM_BE, pend[0].be);
                     check_eq("dm_wdata", DM_WDATA, pend[0].data);
                  end else begin
                     check_eq("dm_stray_write", DM_WE, 0);
                  end
               end else begin
                  check_eq("dm_raddr", DM_ADDR, {cur_ld_addr[31:2], 2'b00});
                  check_eq("dm_rbe", DM_BE, 4'hF);
                  DM_RDATA = {bbyte(DM_ADDR + 3), bbyte(DM_ADDR + 2),
                              bbyte(DM_ADDR + 1), bbyte(DM_ADDR)};
               end
               last_we = DM_WE; last_addr = DM_ADDR; last_be = DM_BE; last_wdata = DM_WDATA;
               DM_ACK  = 1'b1;
            end else begin
               wait_cnt--;
            end
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int busy;
      logic [2:0] f3;
      logic [31:0] a;
      n_tests = 0; n_fail = 0; resp_en = 1'b1; fixed_delay = -1; cur_ld_addr = 32'h0;
      RESET = 1'b0; MEM_READ_EN = 1'b0; MEM_WRITE_EN = 1'b0; FUNC3 = 3'b000;
      ADDR = 32'h0; WRITE_DATA = 32'h0;
      repeat (2) @(negedge CLK);
      #1;
      check_eq("rst_req", DM_REQ, 0);
      check_eq("rst_we", DM_WE, 0);
      check_eq("rst_busy", MEM_BUSYWAIT, 0);
      check_eq("rst_misalign", MISALIGN, 0);
      check_eq("rst_rdata", READ_DATA, 0);
      check_eq("rst_dm_addr", DM_ADDR, 0);
      check_eq("rst_dm_wdata", DM_WDATA, 0);
      check_eq("rst_dm_be", DM_BE, 0);
      check_eq("rst_empty", SB_EMPTY, 1);
      check_eq("rst_full", SB_FULL, 0);
      @(negedge CLK); RESET = 1'b1;

      // Single word store drains to memory.
      do_store(32'h100, 3'b010, 32'hDEADBEEF, 1'b0);
      idle(0);
      #1;
      check_eq("sw_empty_fell", SB_EMPTY, 0);
      wait_empty();

      // Byte store forwarded to a byte load, then a word load that must drain first.
      do_store(32'h203, 3'b000, 32'h00000080, 1'b0);
      do_load(32'h203, 3'b000, busy);
      check_eq("fwd_lb_data", READ_DATA, 32'hFFFFFF80);
      check_eq("fwd_lb_busy", busy, 0);
      do_load(32'h200, 3'b010, busy);
      check_eq("lw_partial_stalled", busy > 1, 1);
      wait_empty();

      // Fill the buffer with the memory not answering; the fifth store must wait.
      disable_resp();
      for (int i = 0; i < 5; i++) begin
         if (i == 4) fork begin repeat (6) @(negedge CLK); resp_en = 1'b1; end join_none
         do_store(32'h600 + 32'(i * 4), 3'b010, $urandom, 1'b0);
      end
      wait_empty();

      // Misaligned halfword load is suppressed.
      do_load(32'h301, 3'b101, busy);
      check_eq("mis_no_req", DM_REQ, 0);
      check_eq("mis_flag", MISALIGN, 1);

      // Unforwarded load latency with a fixed ACK delay.
      wait_empty();
      golden[32'h400] = 8'h78; golden[32'h401] = 8'h56;
      golden[32'h402] = 8'h34; golden[32'h403] = 8'h12;
      backing[32'h400] = 8'h78; backing[32'h401] = 8'h56;
      backing[32'h402] = 8'h34; backing[32'h403] = 8'h12;
      fixed_delay = 2;
      do_load(32'h400, 3'b010, busy);
      check_eq("lw_rdata", READ_DATA, 32'h12345678);
      check_eq("lw_busy_cycles", busy, 4);
      fixed_delay = 0;
      do_load(32'h402, 3'b001, busy);
      check_eq("lh_min_busy", busy, 2);
      fixed_delay = -1;

      // Reset in the middle of a drain.
      wait_empty();
      disable_resp();
      do_store(32'h500, 3'b010, 32'hCAFEF00D, 1'b0);
      for (int i = 0; i < 20 && !DM_REQ; i++) @(negedge CLK);
      check_eq("drain_req_up", DM_REQ, 1);
      @(negedge CLK);
      MEM_WRITE_EN = 1'b0; MEM_READ_EN = 1'b0; RESET = 1'b0;
      #1;
      check_eq("mid_rst_req", DM_REQ, 0);
      check_eq("mid_rst_empty", SB_EMPTY, 1);
      pend.delete();
      golden = backing;
      @(negedge CLK); RESET = 1'b1;
      @(negedge CLK); DM_ACK = 1'b1;
      @(negedge CLK); DM_ACK = 1'b0;
      #1;
      check_eq("late_ack_req", DM_REQ, 0);
      check_eq("late_ack_empty", SB_EMPTY, 1);
      resp_en = 1'b1;
      do_load(32'h500, 3'b010, busy);

      // Random traffic over a small window so addresses collide often.
      for (int op = 0; op < 400; op++) begin
         int r = int'($urandom_range(0, 9));
         int n;
         if (r <= 3) f3 = 3'($urandom_range(0, 2));
         else begin
            f3 = 3'($urandom_range(0, 4));
            if (f3 == 3'b011) f3 = 3'b100;
            else if (f3 == 3'b100) f3 = 3'b101;
         end
         n = nbytes(f3);
         a = 32'h700 + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3));
         if ($urandom_range(0, 4) != 0) a = a & ~32'(n - 1);
         if (r <= 3)      do_store(a, f3, $urandom, $urandom_range(0, 7) == 0);
         else if (r <= 7) do_load(a, f3, busy);
         else             idle(int'($urandom_range(1, 4)));
      end
      wait_empty();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
